// File: rtl/tilelink_ul_reg_slice_pkg.sv
// rtl/tilelink_ul_reg_slice_pkg.sv - shared TileLink-UL widths, opcodes and packed payload sizes
package tilelink_ul_reg_slice_pkg;

    localparam int TL_ADDR_WIDTH   = 64;
    localparam int TL_DATA_WIDTH   = 64;
    localparam int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8;
    localparam int TL_SOURCE_WIDTH = 3;
    localparam int TL_SINK_WIDTH   = 3;
    localparam int TL_OPCODE_WIDTH = 3;
    localparam int TL_PARAM_WIDTH  = 3;
    localparam int TL_SIZE_WIDTH   = 8;

    localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_A_GET              = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

    // A payload: opcode, param, size, source, address, mask, data
    function automatic int tl_a_payload_width(input int opw, input int pw, input int szw,
                                              input int srcw, input int aw, input int dw);
        return opw + pw + szw + srcw + aw + dw / 8 + dw;
    endfunction

    // D payload: opcode, param, size, sink, source, data, error
    function automatic int tl_d_payload_width(input int opw, input int pw, input int szw,
                                              input int sinkw, input int srcw, input int dw);
        return opw + pw + szw + sinkw + srcw + dw + 1;
    endfunction

    localparam int TL_A_PAYLOAD_WIDTH = tl_a_payload_width(TL_OPCODE_WIDTH, TL_PARAM_WIDTH,
        TL_SIZE_WIDTH, TL_SOURCE_WIDTH, TL_ADDR_WIDTH, TL_DATA_WIDTH);
    localparam int TL_D_PAYLOAD_WIDTH = tl_d_payload_width(TL_OPCODE_WIDTH, TL_PARAM_WIDTH,
        TL_SIZE_WIDTH, TL_SINK_WIDTH, TL_SOURCE_WIDTH, TL_DATA_WIDTH);

endpackage

// File: rtl/tilelink_ul_skid_buf.sv
// rtl/tilelink_ul_skid_buf.sv - two-entry skid buffer with registered input ready
module tilelink_ul_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             m_valid;
    logic             s_valid;
    logic             s_valid_nxt;
    logic             in_ready_q;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = m_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    // Skid occupancy after this edge; ready is registered from it so it never sees out_ready combinationally
    always_comb begin
        s_valid_nxt = s_valid;
        if (out_fire) begin
            s_valid_nxt = 1'b0;
        end else if (in_fire && m_valid) begin
            s_valid_nxt = 1'b1;
        end
    end

    // Main/skid register update; ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b0;
            m_data     <= '0;
            s_data     <= '0;
        end else begin
            in_ready_q <= ~s_valid_nxt;
            if (out_fire) begin
                if (s_valid) begin
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                end else if (in_fire) begin
                    m_data <= in_data;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (in_fire) begin
                if (m_valid) begin
                    s_data  <= in_data;
                    s_valid <= 1'b1;
                end else begin
                    m_data  <= in_data;
                    m_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tilelink_ul_reg_slice.sv
// rtl/tilelink_ul_reg_slice.sv - TileLink-UL A/D register slice with outstanding-request limiter
module tilelink_ul_reg_slice
    import tilelink_ul_reg_slice_pkg::*;
#(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_a_valid,
    output logic                       up_a_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] up_a_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  up_a_param,
    input  logic [TL_SIZE_WIDTH-1:0]   up_a_size,
    input  logic [TL_SOURCE_WIDTH-1:0] up_a_source,
    input  logic [TL_ADDR_WIDTH-1:0]   up_a_address,
    input  logic [TL_STRB_WIDTH-1:0]   up_a_mask,
    input  logic [TL_DATA_WIDTH-1:0]   up_a_data,
    output logic                       dn_a_valid,
    input  logic                       dn_a_ready,
    output logic [TL_OPCODE_WIDTH-1:0] dn_a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  dn_a_param,
    output logic [TL_SIZE_WIDTH-1:0]   dn_a_size,
    output logic [TL_SOURCE_WIDTH-1:0] dn_a_source,
    output logic [TL_ADDR_WIDTH-1:0]   dn_a_address,
    output logic [TL_STRB_WIDTH-1:0]   dn_a_mask,
    output logic [TL_DATA_WIDTH-1:0]   dn_a_data,
    input  logic                       dn_d_valid,
    output logic                       dn_d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] dn_d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  dn_d_param,
    input  logic [TL_SIZE_WIDTH-1:0]   dn_d_size,
    input  logic [TL_SINK_WIDTH-1:0]   dn_d_sink,
    input  logic [TL_SOURCE_WIDTH-1:0] dn_d_source,
    input  logic [TL_DATA_WIDTH-1:0]   dn_d_data,
    input  logic                       dn_d_error,
    output logic                       up_d_valid,
    input  logic                       up_d_ready,
    output logic [TL_OPCODE_WIDTH-1:0] up_d_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  up_d_param,
    output logic [TL_SIZE_WIDTH-1:0]   up_d_size,
    output logic [TL_SINK_WIDTH-1:0]   up_d_sink,
    output logic [TL_SOURCE_WIDTH-1:0] up_d_source,
    output logic [TL_DATA_WIDTH-1:0]   up_d_data,
    output logic                       up_d_error,
    output logic [CNT_WIDTH-1:0]       outstanding,
    output logic                       err_underflow
);

    localparam int A_W = tl_a_payload_width(TL_OPCODE_WIDTH, TL_PARAM_WIDTH, TL_SIZE_WIDTH,
                                            TL_SOURCE_WIDTH, TL_ADDR_WIDTH, TL_DATA_WIDTH);
    localparam int D_W = tl_d_payload_width(TL_OPCODE_WIDTH, TL_PARAM_WIDTH, TL_SIZE_WIDTH,
                                            TL_SINK_WIDTH, TL_SOURCE_WIDTH, TL_DATA_WIDTH);

    logic [A_W-1:0] a_pack_in;
    logic [A_W-1:0] a_pack_out;
    logic [D_W-1:0] d_pack_in;
    logic [D_W-1:0] d_pack_out;
    logic           a_buf_ready;
    logic           below_limit;
    logic           up_a_fire;
    logic           up_d_fire;

    assign a_pack_in = {up_a_opcode, up_a_param, up_a_size, up_a_source,
                        up_a_address, up_a_mask, up_a_data};
    assign {dn_a_opcode, dn_a_param, dn_a_size, dn_a_source,
            dn_a_address, dn_a_mask, dn_a_data} = a_pack_out;
    assign d_pack_in = {dn_d_opcode, dn_d_param, dn_d_size, dn_d_sink,
                        dn_d_source, dn_d_data, dn_d_error};
    assign {up_d_opcode, up_d_param, up_d_size, up_d_sink,
            up_d_source, up_d_data, up_d_error} = d_pack_out;

    // Limiter gates both the ready seen upstream and the valid fed to the buffer so they agree on fire
    assign below_limit = (outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
    assign up_a_ready  = a_buf_ready & below_limit;
    assign up_a_fire   = up_a_valid & up_a_ready;
    assign up_d_fire   = up_d_valid & up_d_ready;

    tilelink_ul_skid_buf #(.WIDTH(A_W)) u_a_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (up_a_valid & below_limit),
        .in_ready  (a_buf_ready),
        .in_data   (a_pack_in),
        .out_valid (dn_a_valid),
        .out_ready (dn_a_ready),
        .out_data  (a_pack_out)
    );

    tilelink_ul_skid_buf #(.WIDTH(D_W)) u_d_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dn_d_valid),
        .in_ready  (dn_d_ready),
        .in_data   (d_pack_in),
        .out_valid (up_d_valid),
        .out_ready (up_d_ready),
        .out_data  (d_pack_out)
    );

    // In-flight count: A accepted upstream minus D delivered upstream; an unmatched D flags underflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (up_d_fire && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
            if (up_a_fire && !up_d_fire) begin
                outstanding <= outstanding + CNT_WIDTH'(1);
            end else if (up_d_fire && !up_a_fire && (outstanding != '0)) begin
                outstanding <= outstanding - CNT_WIDTH'(1);
            end
        end
    end

endmodule
